// File: rtl/axis_frame_gen.sv
// AXI-Stream frame generator: emits frames of incrementing payload starting at a seed,
// with an optional error flag on the last beat and a programmable idle gap afterwards.
module axis_frame_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  frame_bad,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [LEN_WIDTH-1:0]  gap_len,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;

  state_t                state, state_next;
  logic [LEN_WIDTH-1:0]  len_q, gap_q, beat_cnt, gap_cnt;
  logic                  bad_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  accept, beat_done, last_beat, gap_done;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    beat_done  = 1'b0;
    last_beat  = (beat_cnt == len_q - LEN_ONE);
    gap_done   = (gap_cnt == gap_q - LEN_ONE);
    case (state)
      IDLE: begin
        if (start && frame_len != '0) begin
          accept     = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (output_axis_tready) begin
          beat_done = 1'b1;
          if (last_beat) state_next = (gap_q != '0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      gap_q    <= '0;
      bad_q    <= 1'b0;
      data_q   <= '0;
      beat_cnt <= '0;
      gap_cnt  <= '0;
      count_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        len_q    <= frame_len;
        gap_q    <= gap_len;
        bad_q    <= frame_bad;
        data_q   <= seed;
        beat_cnt <= '0;
      end
      if (beat_done) begin
        if (last_beat) begin
          count_q <= count_q + CNT_ONE;
          gap_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + LEN_ONE;
          data_q   <= data_q + DATA_ONE;
        end
      end
      // gap_cnt counts completed gap cycles; the last one hands back to IDLE
      if (state == GAP && !gap_done) gap_cnt <= gap_cnt + LEN_ONE;
    end
  end

  // All outputs derive from registers only, so tvalid never sees tready combinationally.
  assign output_axis_tvalid = (state == SEND);
  assign output_axis_tlast  = output_axis_tvalid && last_beat;
  assign output_axis_tuser  = output_axis_tlast && bad_q;
  assign output_axis_tdata  = data_q;
  assign busy               = (state != IDLE);
  assign frame_count        = count_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Bench for axis_frame_gen: directed scenarios plus randomized frames checked against
// an expected-beat list computed from frame parameters.
module tb_axis_frame_gen;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int CW = 16;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, frame_bad = 1'b0, tready = 1'b0;
  logic [LW-1:0] frame_len = '0, gap_len = '0;
  logic [DW-1:0] seed = '0;
  logic [DW-1:0] tdata, tdata4;
  logic tvalid, tlast, tuser, busy, tvalid4, tlast4, tuser4, busy4;
  logic [CW-1:0] frame_count;
  logic [3:0] frame_count4;

  int n_cmp = 0, n_bad = 0, exp_count = 0, stall_viol = 0, mirror_viol = 0;
  logic [DW+1:0] got_q[$];
  logic [DW+1:0] exp_q[$];
  int ready_pat[$];

  always #5 clk = ~clk;

  axis_frame_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len), .frame_bad(frame_bad),
    .seed(seed), .gap_len(gap_len), .output_axis_tdata(tdata), .output_axis_tvalid(tvalid),
    .output_axis_tready(tready), .output_axis_tlast(tlast), .output_axis_tuser(tuser),
    .busy(busy), .frame_count(frame_count));

  axis_frame_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len), .frame_bad(frame_bad),
    .seed(seed), .gap_len(gap_len), .output_axis_tdata(tdata4), .output_axis_tvalid(tvalid4),
    .output_axis_tready(tready), .output_axis_tlast(tlast4), .output_axis_tuser(tuser4),
    .busy(busy4), .frame_count(frame_count4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start request for one edge, then scramble the request fields.
  task automatic do_start(input int len, input int sd, input bit bad, input int gap);
    frame_len = LW'(len); seed = DW'(sd); frame_bad = bad; gap_len = LW'(gap); start = 1'b1;
    step();
    start = 1'b0;
    frame_len = LW'($urandom); seed = DW'($urandom); frame_bad = 1'($urandom); gap_len = LW'($urandom);
  endtask

  // Reference model: beat i carries seed+i, last only on beat len-1, user = bad on last.
  function automatic void build_exp(input int len, input int sd, input bit bad);
    exp_q.delete();
    for (int i = 0; i < len; i++)
      exp_q.push_back({DW'(sd + i), (i == len - 1), (bad && (i == len - 1))});
  endfunction

  function automatic logic [DW+1:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : '1;
  endfunction

  // Drive tready (pattern first, then random) and record every handshaked beat.
  task automatic collect(input int ready_pct, input int max_cyc, output int cycles, output bit timeout);
    logic [DW+1:0] held = '0;
    bit stalled = 0;
    bit done = 0;
    got_q.delete(); cycles = 0; timeout = 0;
    while (!done && !timeout) begin
      if (ready_pat.size() > 0) tready = (ready_pat.pop_front() != 0);
      else tready = ($urandom_range(99) < ready_pct);
      if (stalled && (tvalid !== 1'b1 || {tdata, tlast, tuser} !== held)) stall_viol++;
      if ({tdata4, tvalid4, tlast4, tuser4, busy4} !== {tdata, tvalid, tlast, tuser, busy}) mirror_viol++;
      stalled = tvalid && !tready;
      held = {tdata, tlast, tuser};
      if (tvalid && tready) begin
        got_q.push_back({tdata, tlast, tuser});
        done = tlast;
      end
      step();
      cycles++;
      if (cycles >= max_cyc && !done) timeout = 1;
    end
    tready = 1'b0;
    $display("frame: %0d beats in %0d cycles, frame_count=%0d", got_q.size(), cycles, frame_count);
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_cmp++;
    if ({tvalid, tlast, tuser, busy} !== 4'b0000 || tdata !== '0 || frame_count !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v%b l%b u%b b%b d%h c%0d, want all 0", tvalid, tlast, tuser, busy, tdata, frame_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; bit to;
    do_start(4, 'hFE, 0, 0);
    n_cmp++;
    if (tvalid !== 1'b1) begin n_bad++; $display("FAIL basic_first_valid: got %b want 1", tvalid); end
    build_exp(4, 'hFE, 0);
    collect(100, 50, cyc, to);
    exp_count++;
    n_cmp++;
    if (to || cyc !== 4) begin n_bad++; $display("FAIL basic_cycles: got %0d (timeout %b) want 4", cyc, to); end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL basic_nbeats: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (got_at(i) !== exp_q[i]) begin n_bad++; $display("FAIL basic_beat%0d: got %h want %h", i, got_at(i), exp_q[i]); end
    end
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || frame_count !== CW'(exp_count)) begin
      n_bad++; $display("FAIL basic_after: got v%b b%b c%0d want v0 b0 c%0d", tvalid, busy, frame_count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    do_start(5, 'h3C, 1, 0);
    n_cmp++;
    if (tvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got %b want 1", tvalid); end
    build_exp(5, 'h3C, 1);
    collect(100, 50, cyc, to);
    exp_count++;
    n_cmp++;
    if (to || cyc !== 5) begin n_bad++; $display("FAIL b2b_cycles: got %0d want 5", cyc); end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (got_at(i) !== exp_q[i]) begin n_bad++; $display("FAIL b2b_beat%0d: got %h want %h", i, got_at(i), exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int cyc; bit to;
    ready_pat = '{1, 0, 0, 1, 1};
    stall_viol = 0;
    do_start(3, 'h10, 0, 0);
    build_exp(3, 'h10, 0);
    collect(100, 50, cyc, to);
    exp_count++;
    n_cmp++;
    if (to || cyc !== 5) begin n_bad++; $display("FAIL bp_cycles: got %0d want 5", cyc); end
    n_cmp++;
    if (stall_viol !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol); end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (got_at(i) !== exp_q[i]) begin n_bad++; $display("FAIL bp_beat%0d: got %h want %h", i, got_at(i), exp_q[i]); end
    end
  endtask

  task automatic test_gap();
    int cyc; bit to;
    do_start(1, 'h77, 1, 3);
    build_exp(1, 'h77, 1);
    collect(100, 20, cyc, to);
    exp_count++;
    n_cmp++;
    if (got_at(0) !== exp_q[0] || got_q.size() !== 1) begin
      n_bad++; $display("FAIL gap_beat: got %h (n=%0d) want %h", got_at(0), got_q.size(), exp_q[0]);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (busy !== 1'b1 || tvalid !== 1'b0) begin n_bad++; $display("FAIL gap_busy%0d: got b%b v%b want b1 v0", i, busy, tvalid); end
      frame_len = 8'd5; seed = 8'h55; gap_len = '0; start = 1'b1;
      step();
    end
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || tvalid !== 1'b0) begin n_bad++; $display("FAIL gap_end: got b%b v%b want b0 v0", busy, tvalid); end
    step();
    n_cmp++;
    if (tvalid !== 1'b0) begin n_bad++; $display("FAIL gap_no_queue: got v%b want 0", tvalid); end
    do_start(2, 'h20, 0, 0);
    n_cmp++;
    if (tvalid !== 1'b1 || tdata !== 8'h20) begin n_bad++; $display("FAIL gap_restart: got v%b d%h want v1 d20", tvalid, tdata); end
    collect(100, 20, cyc, to);
    exp_count++;
  endtask

  task automatic test_zero_len();
    do_start(0, 'h99, 1, 2);
    repeat (2) begin
      n_cmp++;
      if (tvalid !== 1'b0 || busy !== 1'b0 || frame_count !== CW'(exp_count)) begin
        n_bad++; $display("FAIL zero_len: got v%b b%b c%0d want v0 b0 c%0d", tvalid, busy, frame_count, exp_count);
      end
      step();
    end
  endtask

  task automatic test_long();
    int cyc; bit to;
    do_start(255, 'h80, 1, 0);
    build_exp(255, 'h80, 1);
    collect(100, 400, cyc, to);
    exp_count++;
    n_cmp++;
    if (to || cyc !== 255) begin n_bad++; $display("FAIL long_cycles: got %0d want 255", cyc); end
    foreach (exp_q[i]) begin
      if (got_at(i) !== exp_q[i]) begin
        n_cmp++; n_bad++; $display("FAIL long_beat%0d: got %h want %h", i, got_at(i), exp_q[i]); break;
      end
    end
    n_cmp++;
    if (got_q.size() !== 255 || got_at(254) !== exp_q[254]) begin
      n_bad++; $display("FAIL long_last: got %h (n=%0d) want %h", got_at(254), got_q.size(), exp_q[254]);
    end
  endtask

  task automatic test_random();
    int cyc, len, sd, gap, pct, g; bit to, bad;
    stall_viol = 0;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(12, 1); sd = $urandom_range(255); bad = 1'($urandom);
      gap = $urandom_range(3); pct = $urandom_range(100, 30);
      do_start(len, sd, bad, gap);
      build_exp(len, sd, bad);
      collect(pct, 2000, cyc, to);
      exp_count++;
      n_cmp++;
      if (to || got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand%0d_nbeats: got %0d want %0d", f, got_q.size(), len); end
      foreach (exp_q[i]) begin
        n_cmp++;
        if (got_at(i) !== exp_q[i]) begin n_bad++; $display("FAIL rand%0d_beat%0d: got %h want %h", f, i, got_at(i), exp_q[i]); end
      end
      g = 0;
      while (busy === 1'b1 && g < 300) begin
        if (tvalid !== 1'b0) stall_viol++;
        step(); g++;
      end
      n_cmp++;
      if (g !== gap || frame_count !== CW'(exp_count)) begin
        n_bad++; $display("FAIL rand%0d_gap: got gap %0d count %0d want gap %0d count %0d", f, g, frame_count, gap, exp_count);
      end
    end
    n_cmp++;
    if (stall_viol !== 0 || mirror_viol !== 0) begin
      n_bad++; $display("FAIL rand_protocol: got %0d stall / %0d mirror errors want 0", stall_viol, mirror_viol);
    end
  endtask

  task automatic test_reset_midframe();
    int cyc; bit to;
    do_start(8, 'hA0, 0, 2);
    tready = 1'b1;
    step(); step();
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || frame_count !== '0 || tdata !== '0) begin
      n_bad++; $display("FAIL rst_mid: got v%b b%b c%0d d%h want 0", tvalid, busy, frame_count, tdata);
    end
    step(); step();
    rst_n = 1'b1;
    step(); step();
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_wait_idle: got v%b b%b want 0", tvalid, busy); end
    tready = 1'b0;
    do_start(8, 'h00, 0, 0);
    build_exp(8, 'h00, 0);
    collect(70, 500, cyc, to);
    exp_count++;
    foreach (exp_q[i]) begin
      n_cmp++;
      if (got_at(i) !== exp_q[i]) begin n_bad++; $display("FAIL rst_restart_beat%0d: got %h want %h", i, got_at(i), exp_q[i]); end
    end
    n_cmp++;
    if (frame_count !== 16'd1) begin n_bad++; $display("FAIL rst_count: got %0d want 1", frame_count); end
  endtask

  task automatic test_count_wrap();
    int cyc; bit to;
    do begin
      do_start(1, $urandom_range(255), 1'($urandom), 0);
      collect(100, 10, cyc, to);
      exp_count++;
      n_cmp++;
      if (frame_count4 !== 4'(exp_count) || frame_count !== CW'(exp_count)) begin
        n_bad++; $display("FAIL wrap_count: got %0d/%0d want %0d/%0d", frame_count4, frame_count, exp_count % 16, exp_count);
      end
    end while (exp_count % 16 != 0);
    n_cmp++;
    if (frame_count4 !== 4'd0 || frame_count !== 16'd16) begin
      n_bad++; $display("FAIL wrap_zero: got %0d/%0d want 0/16", frame_count4, frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_gap();
    test_zero_len();
    test_long();
    test_random();
    test_reset_midframe();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
